// File: rtl/ddr_burst_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ddr_burst_master: 64-bit DDR burst initiator with a credit-gated read FIFO.
// Revision 1.0
// ---------------------------------------------------------------------------
module ddr_burst_master #(
  parameter int FifoDepth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [LenWidth-1:0] cmd_len_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [63:0]         wr_data_i,
  input  logic [7:0]          wr_strb_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [63:0]         rd_data_o,
  output logic                rd_last_o,
  output logic [31:0]         mem_addr_o,
  output logic [63:0]         mem_data_o,
  output logic                mem_write_en_o,
  output logic                mem_read_en_o,
  output logic [7:0]          mem_byte_en_o,
  input  logic [63:0]         mem_data_i,
  input  logic                mem_data_valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW:0] CreditMax = (CntW+1)'(FifoDepth);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [LenWidth-1:0] rem_q, rem_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic [LenWidth-1:0] popped_q, popped_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     outst_q, outst_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [63:0]         fifo_mem [FifoDepth];

  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [63:0]         mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [7:0]          mem_be_q, mem_be_d;

  logic                wr_hs, issue, push, pop;
  logic [CntW:0]       credit_used;

  // A read may only be issued if its return is guaranteed a FIFO slot.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q};
  assign issue       = (state_q == S_READ) && (rem_q != '0) && (credit_used < CreditMax);
  assign push        = mem_data_valid_i && (outst_q != '0);
  assign pop         = rd_valid_o && rd_ready_i;
  assign wr_hs       = wr_valid_i && wr_ready_o;

  assign cmd_ready_o    = (state_q == S_IDLE);
  assign wr_ready_o     = (state_q == S_WRITE) && (rem_q != '0);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = (state_q == S_DONE);
  assign err_o          = done_o && err_q;
  assign rd_valid_o     = (count_q != '0);
  assign rd_data_o      = rd_valid_o ? fifo_mem[rptr_q] : '0;
  assign rd_last_o      = rd_valid_o && (popped_q == len_q - LenWidth'(1));
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign mem_write_en_o = mem_we_q;
  assign mem_read_en_o  = mem_re_q;
  assign mem_byte_en_o  = mem_be_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    err_d      = err_q;
    popped_d   = popped_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    mem_re_d   = 1'b0;
    mem_be_d   = 8'h00;

    if (pop) popped_d = popped_q + LenWidth'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_addr_i;
          len_d    = cmd_len_i;
          rem_d    = cmd_len_i;
          popped_d = '0;
          err_d    = (cmd_addr_i[2:0] != 3'b000);
          if (err_d || (cmd_len_i == '0)) state_d = S_DONE;
          else                            state_d = cmd_write_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (wr_hs) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = wr_data_i;
          mem_be_d   = wr_strb_i;
          addr_d     = addr_q + 32'd8;
          rem_d      = rem_q - LenWidth'(1);
          if (rem_q == LenWidth'(1)) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (issue) begin
          mem_re_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_be_d   = 8'hFF;
          addr_d     = addr_q + 32'd8;
          rem_d      = rem_q - LenWidth'(1);
          if (rem_q == LenWidth'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && rd_last_o) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    count_d = count_q;
    if (issue && !push)      outst_d = outst_q + CntW'(1);
    else if (!issue && push) outst_d = outst_q - CntW'(1);
    if (push && !pop)        count_d = count_q + CntW'(1);
    else if (!push && pop)   count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      popped_q   <= '0;
      err_q      <= 1'b0;
      outst_q    <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      popped_q   <= popped_d;
      err_q      <= err_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      mem_re_q   <= mem_re_d;
      mem_be_q   <= mem_be_d;
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= mem_data_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr_burst_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ddr_burst_master: command table, random bursts and reset corner cases
// against a fixed-latency DDR memory model. Revision 1.0
// ---------------------------------------------------------------------------
module tb_ddr_burst_master;
  localparam int DEPTH = 32;
  localparam int LW    = 16;
  localparam int LAT   = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
  logic [31:0]   cmd_addr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          cmd_ready_o;
  logic          wr_valid_i = 1'b0, wr_ready_o;
  logic [63:0]   wr_data_i = '0;
  logic [7:0]    wr_strb_i = '0;
  logic          rd_valid_o, rd_ready_i = 1'b0, rd_last_o;
  logic [63:0]   rd_data_o;
  logic [31:0]   mem_addr_o;
  logic [63:0]   mem_data_o;
  logic          mem_write_en_o, mem_read_en_o;
  logic [7:0]    mem_byte_en_o;
  logic [63:0]   mem_data_i = '0;
  logic          mem_data_valid_i = 1'b0;
  logic          busy_o, done_o, err_o;

  always #5 clk = ~clk;

  ddr_burst_master #(.FifoDepth(DEPTH), .LenWidth(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_en_o(mem_write_en_o),
    .mem_read_en_o(mem_read_en_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_data_i(mem_data_i), .mem_data_valid_i(mem_data_valid_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int total = 0, bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, want);
    end
  endfunction

  // DDR device model: word-addressed store, unwritten words read as an address hash.
  logic [63:0] mem_model [logic [31:0]];

  function automatic logic [63:0] model_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {~a, a ^ 32'h5A5A_0000};
  endfunction

  typedef struct {logic [31:0] addr; logic [63:0] data; logic [7:0] strb;} wr_t;
  typedef struct {logic [63:0] data; logic last; int cyc;} rd_t;
  typedef struct {int due; logic [63:0] data;} ret_t;

  wr_t         wq[$];
  logic [31:0] raddrs[$];
  rd_t         rdq[$];
  ret_t        retq[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_we_cyc = 0;
  int viol = 0, rdv_seen = 0, strobe_cnt = 0, stalled_issues = 0;
  logic done_err = 1'b0;

  always @(negedge clk) begin : mon
    ret_t        r;
    logic [63:0] w;
    cyc++;
    if (rd_valid_o) rdv_seen++;
    if (rd_valid_o && rd_ready_i) rdq.push_back('{rd_data_o, rd_last_o, cyc});
    if (mem_write_en_o) begin
      wq.push_back('{mem_addr_o, mem_data_o, mem_byte_en_o});
      w = model_read(mem_addr_o);
      for (int b = 0; b < 8; b++)
        if (mem_byte_en_o[b]) w[8*b +: 8] = mem_data_o[8*b +: 8];
      mem_model[mem_addr_o] = w;
      last_we_cyc = cyc;
      strobe_cnt++;
    end
    if (mem_read_en_o) begin
      raddrs.push_back(mem_addr_o);
      retq.push_back('{cyc + LAT, model_read(mem_addr_o)});
      strobe_cnt++;
      if (mem_byte_en_o != 8'hFF) viol++;
    end
    if (mem_write_en_o && mem_read_en_o) viol++;
    if ((mem_write_en_o || mem_read_en_o) && (mem_addr_o[2:0] != 3'b000)) viol++;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err_o;
    end
    if (err_o && !done_o) viol++;
    mem_data_valid_i = 1'b0;
    mem_data_i       = '0;
    if (retq.size() > 0 && retq[0].due <= cyc) begin
      r = retq.pop_front();
      mem_data_valid_i = 1'b1;
      mem_data_i       = r.data;
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len,
                         input int data_base, input int wpct, input int rpct,
                         input int stall, input bit exp_err, input int exp_strobes,
                         input string tag);
    logic [63:0] ed[$];
    logic [7:0]  es[$];
    logic [31:0] ea;
    int idx, k, d0, s0, budget;
    bit whs;
    for (int i = 0; i < len; i++) begin
      if (data_base != 0) begin
        ed.push_back(64'(data_base + i));
        es.push_back(8'hFF);
      end else begin
        ed.push_back({$urandom, $urandom});
        es.push_back(8'($urandom_range(255)));
      end
    end
    wq.delete(); raddrs.delete(); rdq.delete();
    d0 = done_cnt; s0 = strobe_cnt; idx = 0; k = 0;
    budget = stall + 20*len + 200;
    cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = LW'(len); cmd_valid_i = 1'b1;
    while (!cmd_ready_o && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      if (k == stall) stalled_issues = raddrs.size();
      wr_valid_i = wr && (idx < len) && ($urandom_range(99) < wpct);
      if (idx < len) begin wr_data_i = ed[idx]; wr_strb_i = es[idx]; end
      rd_ready_i = (k >= stall) && ($urandom_range(99) < rpct);
      whs = wr_valid_i && wr_ready_o;
      @(posedge clk); #1;
      if (whs) idx++;
      k++;
    end
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    if (done_cnt == d0) begin
      do_reset();
      return;
    end
    check({tag, " busy after done"}, 64'(busy_o), 64'd0);
    check({tag, " cmd_ready after done"}, 64'(cmd_ready_o), 64'd1);
    check({tag, " err flag"}, 64'(done_err), 64'(exp_err));
    check({tag, " strobes"}, 64'(strobe_cnt - s0), 64'(exp_strobes));
    if (wr && !exp_err) begin
      check({tag, " write count"}, 64'(wq.size()), 64'(len));
      for (int i = 0; i < len && i < wq.size(); i++) begin
        ea = addr + 32'(8*i);
        check($sformatf("%s wr%0d addr", tag, i), 64'(wq[i].addr), 64'(ea));
        check($sformatf("%s wr%0d data", tag, i), wq[i].data, ed[i]);
        check($sformatf("%s wr%0d strb", tag, i), 64'(wq[i].strb), 64'(es[i]));
      end
      if (len > 0) check({tag, " done with last write"}, 64'(done_cyc), 64'(last_we_cyc));
    end
    if (!wr && !exp_err) begin
      check({tag, " read issues"}, 64'(raddrs.size()), 64'(len));
      check({tag, " read words"}, 64'(rdq.size()), 64'(len));
      for (int i = 0; i < len && i < rdq.size() && i < raddrs.size(); i++) begin
        ea = addr + 32'(8*i);
        check($sformatf("%s rd%0d addr", tag, i), 64'(raddrs[i]), 64'(ea));
        check($sformatf("%s rd%0d data", tag, i), rdq[i].data, model_read(ea));
        check($sformatf("%s rd%0d last", tag, i), 64'(rdq[i].last), 64'(i == len - 1));
      end
      if (len > 0 && rdq.size() == len)
        check({tag, " done after last pop"}, 64'(done_cyc), 64'(rdq[len-1].cyc + 1));
    end
  endtask

  typedef struct {
    bit wr; logic [31:0] addr; int len; int data_base;
    int wpct; int rpct; bit exp_err; int exp_strobes;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int   k, s0, rdv0;
    tbl[0] = '{1'b1, 32'h0000_0100, 4,  'hA0, 100, 100, 1'b0, 4};
    tbl[1] = '{1'b0, 32'h0000_0100, 4,  0,    100, 100, 1'b0, 4};
    tbl[2] = '{1'b0, 32'h0000_0104, 4,  0,    100, 100, 1'b1, 0};
    tbl[3] = '{1'b1, 32'h0000_0104, 3,  0,    100, 100, 1'b1, 0};
    tbl[4] = '{1'b0, 32'h0000_0200, 0,  0,    100, 100, 1'b0, 0};
    tbl[5] = '{1'b1, 32'hFFFF_FFF8, 2,  'hC0, 100, 100, 1'b0, 2};
    tbl[6] = '{1'b0, 32'hFFFF_FFF8, 2,  0,    100, 50,  1'b0, 2};
    tbl[7] = '{1'b1, 32'h0000_0300, 10, 0,    40,  100, 1'b0, 10};

    repeat (3) @(posedge clk);
    #1;
    check("reset cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done/err", 64'({done_o, err_o}), 64'd0);
    check("reset wr_ready", 64'(wr_ready_o), 64'd0);
    check("reset rd_valid/last", 64'({rd_valid_o, rd_last_o}), 64'd0);
    check("reset mem strobes", 64'({mem_write_en_o, mem_read_en_o}), 64'd0);
    check("reset mem_addr", 64'(mem_addr_o), 64'd0);
    check("reset mem_byte_en", 64'(mem_byte_en_o), 64'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].data_base, tbl[i].wpct,
              tbl[i].rpct, 0, tbl[i].exp_err, tbl[i].exp_strobes, $sformatf("vec%0d", i));
      if (i == 1 && rdq.size() == 4) begin
        check("vec1 first word", rdq[0].data, 64'hA0);
        check("vec1 final word", rdq[3].data, 64'hA3);
      end
      if (i == 5 && wq.size() == 2) check("vec5 wrapped addr", 64'(wq[1].addr), 64'h0);
    end

    // Long read with the consumer stalled: only a FIFO's worth may be issued.
    run_cmd(1'b0, 32'h0000_1000, 100, 0, 100, 100, 200, 1'b0, 100, "stall");
    check("stall issues while blocked", 64'(stalled_issues), 64'(DEPTH));

    for (int n = 0; n < 12; n++) begin
      bit          rw, re;
      logic [31:0] ra;
      int          rl;
      rw = 1'($urandom_range(1));
      ra = 32'h0001_0000 + 32'($urandom_range(255) * 8);
      if ($urandom_range(5) == 0) ra = ra + 32'd4;
      rl = int'($urandom_range(48));
      re = (ra[2:0] != 3'b000);
      run_cmd(rw, ra, rl, 0, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              0, re, re ? 0 : rl, $sformatf("rand%0d", n));
    end

    // Reset with five reads in flight; their late returns must be ignored.
    raddrs.delete();
    cmd_write_i = 1'b0; cmd_addr_i = 32'h0000_0100; cmd_len_i = LW'(5); cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    rd_ready_i  = 1'b1;
    k = 0;
    while (raddrs.size() < 5 && k < 50) begin @(posedge clk); #1; k++; end
    check("rst reads in flight", 64'(raddrs.size()), 64'd5);
    rst_i = 1'b1;
    #1;
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst strobes/valid", 64'({mem_read_en_o, mem_write_en_o, rd_valid_o, done_o}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    s0 = strobe_cnt; rdv0 = rdv_seen; k = 0;
    while (retq.size() > 0 && k < 100) begin @(posedge clk); #1; k++; end
    repeat (3) @(posedge clk);
    #1;
    rd_ready_i = 1'b0;
    check("rst stale returns delivered", 64'(retq.size()), 64'd0);
    check("rst stale returns dropped", 64'(rdv_seen - rdv0), 64'd0);
    check("rst no strobes after reset", 64'(strobe_cnt - s0), 64'd0);
    run_cmd(1'b0, 32'h0000_0108, 1, 0, 100, 100, 0, 1'b0, 1, "post-rst");
    if (rdq.size() == 1) check("post-rst word", rdq[0].data, 64'hA1);

    check("protocol invariants", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ddr_burst_master.md
Name: ddr_burst_master

Overview:
- Initiator for the 64-bit DDR word interface: turns one command (base address, word count, direction) into a sequence of aligned single-word accesses.
- Write data comes from a ready/valid input stream; read data goes to a ready/valid output stream.
- Read data returns after a fixed memory latency with no stall, so the block issues reads on a credit basis against an internal return FIFO.
- Sits between accelerator DMA logic (layer weights, activations) and the DDR model or controller.

Parameters:
- FifoDepth, 32, read-return FIFO depth in 64-bit words. Must be a power of two and ≥ 2. Full read throughput requires FifoDepth ≥ memory read latency + 2.
- LenWidth, 16, width of the command word count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready; high only in IDLE
- cmd_write_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  32  byte base address
- cmd_len_i  in  LenWidth  number of 64-bit words
- wr_valid_i  in  1  write data valid
- wr_ready_o  out  1  write data ready
- wr_data_i  in  64  write data
- wr_strb_i  in  8  byte enables for write data
- rd_valid_o  out  1  read data valid
- rd_ready_i  in  1  read data ready
- rd_data_o  out  64  read data
- rd_last_o  out  1  marks the final word of the read command
- mem_addr_o  out  32  memory byte address, always 8-byte aligned
- mem_data_o  out  64  memory write data
- mem_write_en_o  out  1  memory write strobe
- mem_read_en_o  out  1  memory read strobe
- mem_byte_en_o  out  8  memory byte enables
- mem_data_i  in  64  memory read data
- mem_data_valid_i  in  1  memory read data valid
- busy_o  out  1  high whenever the state is not IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse, coincident with done_o, for an unaligned command

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o = 1. FIFO empty, outstanding = 0, state = IDLE.
- All mem_* outputs are registered. mem_write_en_o and mem_read_en_o are never both high.
- States are IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - Command accepted on cmd_valid_i & cmd_ready_o; address and length are latched.
  - If cmd_addr_i[2:0] ≠ 0, go to DONE with err flagged; no memory traffic.
  - If len = 0, go to DONE.
  - Otherwise go to WRITE or READ according to cmd_write_i.
- WRITE:
  - wr_ready_o = 1 while remaining > 0.
  - Each wr handshake causes, next cycle: mem_write_en_o = 1, mem_addr_o = current address, mem_data_o = wr_data_i, mem_byte_en_o = wr_strb_i. Then address += 8 and remaining -= 1.
  - The cycle after the last handshake (the same cycle as the last mem_write_en_o), go to DONE.
  - With no handshake, mem_write_en_o = 0.
- READ:
  - Issue a read (mem_read_en_o = 1, mem_byte_en_o = 8'hFF, address += 8) in any cycle where outstanding + fifo_count < FifoDepth.
  - outstanding increments per issued read and decrements per mem_data_valid_i.
  - After the last issue, go to DRAIN.
- Return path:
  - mem_data_valid_i with outstanding > 0 pushes mem_data_i into the FIFO.
  - mem_data_valid_i with outstanding = 0 is dropped. This covers stale returns after a reset.
  - A push and a pop in the same cycle leave the count unchanged.
- Read output:
  - rd_valid_o = FIFO not empty. rd_data_o = FIFO head (show-ahead).
  - rd_last_o = 1 with the head word when that word is the final word of the command. This is tracked by a popped-word counter.
- DRAIN: go to DONE on the handshake of the rd_last_o word.
- DONE: done_o = 1 (and err_o if flagged) for one cycle, then IDLE. A new command can be accepted the following cycle.
- Address arithmetic is modulo 2^32; a wrap from 0xFFFFFFF8 to 0x00000000 is silent.
- Reset mid-burst: immediate return to the reset state. The FIFO is flushed and no further memory strobes are issued.

Test Plan:
- Write addr=0x100, len=4, wr_valid held high, data 0xA0..0xA3, strb 0xFF -> 4 consecutive mem_write_en_o at 0x100/0x108/0x110/0x118, done_o 1 cycle after, busy_o low the next cycle.
- Read addr=0x100, len=4, latency 16, rd_ready_i=1 -> 4 back-to-back mem_read_en_o; rd_data_o = 0xA0..0xA3 in order; rd_last_o only on 0xA3; done_o after that handshake.
- Read len=100, FifoDepth=32, rd_ready_i=0 for 200 cycles then 1 -> exactly 32 reads issued while stalled, no FIFO overflow, all 100 words delivered in order.
- Command with addr=0x104 -> err_o and done_o pulse together, no mem strobes; len=0 command -> done_o only, err_o = 0.
- Write addr=0xFFFFFFF8, len=2 -> accesses at 0xFFFFFFF8 then 0x00000000.
- Assert rst_i mid-read with 5 words in flight -> outputs at reset values; the 5 late mem_data_valid_i are dropped; a following read of len=1 returns the correct single word.
